sram_port_arbiter: RTL
======================

// Module: sram_port_arbiter
// PURPOSE
// Shares the single external 8-bit async SRAM between the SAM core (priority requester)
// and the host control module (ROM/disk image DMA).
// Sits between both requesters and the top-level SRAM pins; the top level builds the inout from data_o/data_oe.
// Sequences each access as a fixed-timing read or write cycle and guarantees the host a slot within a bounded wait.
// PARAMETERS
// ADDR_W         21  SRAM address width
// WR_CYCLES       2  clocks sram_we_n is held low per write (>=1)
// HOST_MAX_WAIT   4  consecutive core grants allowed while host_req pending (>=1)
// PORTS
// clk            in   1       single clock, clk24 domain
// reset_n        in   1       asynchronous, active-low reset
// core_req       in   1       core request, level, held until core_ack
// core_we        in   1       1=write, 0=read; sampled at grant
// core_addr      in   ADDR_W  sampled at grant
// core_wdata     in   8       sampled at grant
// core_rdata     out  8       read data, valid while core_ack=1, held until next core read
// core_ack       out  1       one-cycle completion pulse
// host_req/host_we/host_addr/host_wdata/host_rdata/host_ack  same as core_*, host side
// sram_addr      out  ADDR_W  SRAM address
// sram_data_i    in   8       SRAM data pins (read)
// sram_data_o    out  8       SRAM write data
// sram_data_oe   out  1       1 = drive sram_data_o onto pins
// sram_we_n      out  1       SRAM write strobe, active low
// BEHAVIOUR
// Reset (async, any state): state=IDLE, sram_we_n=1, sram_data_oe=0, sram_addr=0, sram_data_o=0,
//   core_ack=host_ack=0, core_rdata=host_rdata=0, starve_cnt=0; an in-flight access is abandoned, no ack.
// States: IDLE, RD_ADDR, RD_SAMPLE, WR_SETUP, WR_PULSE, WR_HOLD, ACK.
// IDLE arbitration (one decision per clock):
//   host wins if host_req && (!core_req || starve_cnt==HOST_MAX_WAIT); else core wins if core_req.
//   Winner's we/addr/wdata latched; owner flag latched; next = RD_ADDR (we=0) or WR_SETUP (we=1).
//   Core grant with host_req=1: starve_cnt++ (saturating at HOST_MAX_WAIT). Host grant: starve_cnt=0.
//   Core grant with host_req=0: starve_cnt unchanged.
// Read: RD_ADDR drives sram_addr (1 clk setup); RD_SAMPLE registers sram_data_i into owner's rdata
//   at its closing edge; ACK pulses owner's ack. Latency grant-edge -> ack high = 3 clocks.
// Write: WR_SETUP drives addr, data_o, data_oe=1, we_n=1; WR_PULSE we_n=0 for WR_CYCLES clocks (counter);
//   WR_HOLD we_n=1, addr/data/oe held; ACK: oe=0, ack pulse. Grant -> ack = 3+WR_CYCLES clocks.
// sram_addr/sram_data_o are stable across the whole access; we_n never falls in the same clock
//   as an address change; data_oe is never 1 during RD_* states.
// ACK always returns to IDLE; at most one ack pulses per clock, only for the latched owner.
// Requester rule: req deasserted, or a new request presented, in the clock after ack.
// Dropping req mid-access does not abort; the access completes and ack still pulses.
// Simultaneous core_req/host_req in IDLE: core wins unless starve_cnt==HOST_MAX_WAIT.
// Inputs changing after grant have no effect on the current access.
// TESTING
// T1 core read addr 0x008FD5, SRAM model holds 0xA5 -> core_ack 3 clks after grant, core_rdata=0xA5, host_ack stays 0.
// T2 host write 0x1FFFFF<=0x3C, WR_CYCLES=2 -> sram_we_n low exactly 2 clks, addr/data stable
//    from WR_SETUP to ACK, host_ack at clk 5; readback via core = 0x3C.
// T3 core_req held continuously, host_req raised -> host granted after exactly 4 core grants, then starve_cnt=0.
// T4 core_req and host_req rise same clock, starve_cnt=0 -> core first, host next; both rdata correct, acks never overlap.
// T5 reset_n low during WR_PULSE -> same-clock async: we_n=1, oe=0, no ack; after release IDLE, starve_cnt=0.
// T6 host drops req during RD_SAMPLE -> host_ack still pulses once, no re-grant while req low.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one async 8-bit SRAM between the core and the host.
// Core has priority; the host is served after at most HOST_MAX_WAIT core grants.
module sram_port_arbiter #(
  parameter int ADDR_W        = 21,
  parameter int WR_CYCLES     = 2,
  parameter int HOST_MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [7:0]        core_wdata,
  output logic [7:0]        core_rdata,
  output logic              core_ack,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic [7:0]        host_rdata,
  output logic              host_ack,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [7:0]        sram_data_i,
  output logic [7:0]        sram_data_o,
  output logic              sram_data_oe,
  output logic              sram_we_n
);

  localparam int CW = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
  localparam int SW = $clog2(HOST_MAX_WAIT + 1);

  localparam logic [CW-1:0] WR_LAST    = CW'(WR_CYCLES - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(HOST_MAX_WAIT);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_SAMPLE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    ACK
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wdata;
  } acc_t;

  state_t          state_q;
  state_t          state_d;
  acc_t            acc_q;
  acc_t            sel;
  logic            owner_q;
  logic [SW-1:0]   starve_q;
  logic [CW-1:0]   wcnt_q;
  logic            starved;
  logic            host_win;
  logic            core_win;
  logic            grant;

  // Host wins only when the core is idle or the host has waited long enough.
  always_comb begin
    starved  = (starve_q == STARVE_MAX);
    host_win = host_req && (!core_req || starved);
    core_win = core_req && !host_win;
    sel      = host_win ? {host_we, host_addr, host_wdata}
                        : {core_we, core_addr, core_wdata};
  end

  assign grant = (state_q == IDLE) && (host_win || core_win);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          host_win,
          core_win: state_d = sel.we ? WR_SETUP : RD_ADDR;
          default:  state_d = IDLE;
        endcase
      end
      RD_ADDR:   state_d = RD_SAMPLE;
      RD_SAMPLE: state_d = ACK;
      WR_SETUP:  state_d = WR_PULSE;
      WR_PULSE: begin
        if (wcnt_q == WR_LAST) begin
          state_d = WR_HOLD;
        end
      end
      WR_HOLD:   state_d = ACK;
      ACK:       state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    sram_we_n    = 1'b1;
    sram_data_oe = 1'b0;
    core_ack     = 1'b0;
    host_ack     = 1'b0;
    unique case (state_q)
      WR_SETUP,
      WR_HOLD: sram_data_oe = 1'b1;
      WR_PULSE: begin
        sram_data_oe = 1'b1;
        sram_we_n    = 1'b0;
      end
      ACK: begin
        core_ack = !owner_q;
        host_ack = owner_q;
      end
      default: ;
    endcase
  end

  // Address and write data come straight from the latched request,
  // so they cannot move until the next grant.
  assign sram_addr   = acc_q.addr;
  assign sram_data_o = acc_q.wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q   <= '0;
      owner_q <= 1'b0;
    end else if (grant) begin
      acc_q   <= sel;
      owner_q <= host_win;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_q <= '0;
    end else if (grant) begin
      if (host_win) begin
        starve_q <= '0;
      end else if (host_req && !starved) begin
        starve_q <= starve_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wcnt_q <= '0;
    end else if (state_q == WR_PULSE) begin
      wcnt_q <= wcnt_q + CW'(1);
    end else begin
      wcnt_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_rdata <= '0;
      host_rdata <= '0;
    end else if (state_q == RD_SAMPLE) begin
      if (owner_q) begin
        host_rdata <= sram_data_i;
      end else begin
        core_rdata <= sram_data_i;
      end
    end
  end

endmodule
